// File: rtl/exu_issue_ctrl_if.sv
// Decode, execute-unit and writeback signal bundle for exu_issue_ctrl.
// slave: the issue controller. master: the surrounding pipeline / testbench.
interface exu_issue_ctrl_if #(
  parameter int unsigned FUNC_W = 4,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned PERF_W = 32
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [63:0]       in_opr_a_i;
  logic [63:0]       in_opr_b_i;
  logic [FUNC_W-1:0] in_func_i;
  logic              in_word_op_i;
  logic              in_mul_i;
  logic              in_div_i;
  logic [RD_W-1:0]   in_rd_i;
  logic [63:0]       exu_opr_a_o;
  logic [63:0]       exu_opr_b_o;
  logic [FUNC_W-1:0] exu_func_o;
  logic              exu_word_op_o;
  logic              exu_mul_instr_o;
  logic              exu_div_instr_o;
  logic              exu_flush_o;
  logic              exu_kill_o;
  logic [63:0]       exu_res_i;
  logic              exu_valid_res_i;
  logic              exu_busy_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [RD_W-1:0]   wb_rd_o;
  logic [63:0]       wb_data_o;
  logic [PERF_W-1:0] perf_issue_o;
  logic [PERF_W-1:0] perf_wait_o;

  modport slave (
    input  flush_i, in_valid_i, in_opr_a_i, in_opr_b_i, in_func_i, in_word_op_i,
           in_mul_i, in_div_i, in_rd_i, exu_res_i, exu_valid_res_i, exu_busy_i, wb_ready_i,
    output in_ready_o, exu_opr_a_o, exu_opr_b_o, exu_func_o, exu_word_op_o, exu_mul_instr_o,
           exu_div_instr_o, exu_flush_o, exu_kill_o, wb_valid_o, wb_rd_o, wb_data_o,
           perf_issue_o, perf_wait_o
  );

  modport master (
    output flush_i, in_valid_i, in_opr_a_i, in_opr_b_i, in_func_i, in_word_op_i,
           in_mul_i, in_div_i, in_rd_i, exu_res_i, exu_valid_res_i, exu_busy_i, wb_ready_i,
    input  in_ready_o, exu_opr_a_o, exu_opr_b_o, exu_func_o, exu_word_op_o, exu_mul_instr_o,
           exu_div_instr_o, exu_flush_o, exu_kill_o, wb_valid_o, wb_rd_o, wb_data_o,
           perf_issue_o, perf_wait_o
  );
endinterface

// File: rtl/exu_issue_ctrl.sv
// Single-issue sequencer in front of the execute unit (ALU / mul / div).
// Accepts one op, registers operands, starts the unit, waits for the result and
// offers it to writeback over valid/ready. Flush cancels everything, killing a
// mul/div in flight.
// Optional: define EXU_PERF_CNT_EN to build saturating issue / wait-cycle counters;
// otherwise the perf ports are tied to zero.
module exu_issue_ctrl #(
  parameter int unsigned FUNC_W = 4,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned PERF_W = 32
) (
  input logic             clk,
  input logic             reset,
  exu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StWait, StWb} state_e;

  state_e            r_state;
  logic [63:0]       r_opr_a;
  logic [63:0]       r_opr_b;
  logic [FUNC_W-1:0] r_func;
  logic              r_word;
  logic [RD_W-1:0]   r_rd;
  logic              r_is_mul;
  logic              r_is_div;
  logic [63:0]       r_data;

  logic w_in_ready;
  logic w_accept;
  logic w_long_op;
  logic w_start;

  // Back-to-back accept is allowed on the writeback handshake cycle.
  assign w_in_ready = ((r_state == StIdle) | ((r_state == StWb) & bus.wb_ready_i)) &
                      ~bus.flush_i;
  assign w_accept   = bus.in_valid_i & w_in_ready;
  assign w_long_op  = r_is_mul | r_is_div;
  assign w_start    = (r_state == StExec) & w_long_op & ~bus.exu_busy_i & ~bus.flush_i;

  // Sequencer FSM plus operand / result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_opr_a  <= '0;
      r_opr_b  <= '0;
      r_func   <= '0;
      r_word   <= 1'b0;
      r_rd     <= '0;
      r_is_mul <= 1'b0;
      r_is_div <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_accept) begin
        r_opr_a  <= bus.in_opr_a_i;
        r_opr_b  <= bus.in_opr_b_i;
        r_func   <= bus.in_func_i;
        r_word   <= bus.in_word_op_i;
        r_rd     <= bus.in_rd_i;
        // Multiply wins when decode flags both classes.
        r_is_mul <= bus.in_mul_i;
        r_is_div <= bus.in_div_i & ~bus.in_mul_i;
      end
      if (bus.flush_i) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_accept) r_state <= StExec;
          end
          StExec: begin
            if (!w_long_op) begin
              r_data  <= bus.exu_res_i;
              r_state <= StWb;
            end else if (!bus.exu_busy_i) begin
              r_state <= StWait;
            end
          end
          StWait: begin
            if (bus.exu_valid_res_i) begin
              r_data  <= bus.exu_res_i;
              r_state <= StWb;
            end
          end
          StWb: begin
            if (bus.wb_ready_i) r_state <= w_accept ? StExec : StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.in_ready_o      = w_in_ready;
  assign bus.exu_opr_a_o     = r_opr_a;
  assign bus.exu_opr_b_o     = r_opr_b;
  assign bus.exu_func_o      = r_func;
  assign bus.exu_word_op_o   = r_word;
  assign bus.exu_mul_instr_o = w_start & r_is_mul;
  assign bus.exu_div_instr_o = w_start & r_is_div;
  assign bus.exu_flush_o     = bus.flush_i;
  assign bus.exu_kill_o      = bus.flush_i &
                               ((r_state == StWait) | ((r_state == StExec) & w_long_op));
  assign bus.wb_valid_o      = (r_state == StWb) & ~bus.flush_i;
  assign bus.wb_rd_o         = r_rd;
  assign bus.wb_data_o       = r_data;

`ifdef EXU_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PerfOne = PERF_W'(1);

  logic [PERF_W-1:0] r_perf_issue;
  logic [PERF_W-1:0] r_perf_wait;

  // Saturating counters; only reset clears them, flush does not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_issue <= '0;
      r_perf_wait  <= '0;
    end else begin
      if (w_accept && (r_perf_issue != '1)) r_perf_issue <= r_perf_issue + PerfOne;
      if ((r_state == StWait) && (r_perf_wait != '1)) r_perf_wait <= r_perf_wait + PerfOne;
    end
  end

  assign bus.perf_issue_o = r_perf_issue;
  assign bus.perf_wait_o  = r_perf_wait;
`else
  assign bus.perf_issue_o = {PERF_W{1'b0}};
  assign bus.perf_wait_o  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Self-checking bench for exu_issue_ctrl: directed transaction table, hand-written
// back-to-back and async-reset sequences, then randomized transactions whose
// expected timing comes from a transaction-level model.
module tb_exu_issue_ctrl;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned PERF_W = 32;

  logic clk = 1'b0;
  logic reset;

  exu_issue_ctrl_if #(.FUNC_W(FUNC_W), .RD_W(RD_W), .PERF_W(PERF_W)) bus_if ();

  exu_issue_ctrl #(.FUNC_W(FUNC_W), .RD_W(RD_W), .PERF_W(PERF_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // cls: 0 ALU, 1 mul, 2 div, 3 mul+div flags. k counts cycles from accept (k=0).
  // exp_start: cycle of start pulse, exp_wbs: first cycle wb_valid is high,
  // exp_wait: WAIT cycles counted, exp_kill: kill on the flush cycle.
  typedef struct {
    int                cls;
    logic [63:0]       a;
    logic [63:0]       b;
    logic [FUNC_W-1:0] func;
    logic              word;
    logic [RD_W-1:0]   rd;
    int                busy;
    int                lat;
    int                stall;
    int                flush_at;
    int                exp_start;
    int                exp_wbs;
    int                exp_wait;
    logic              exp_kill;
  } txn_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] m_issue = '0;
  logic [63:0] m_wait  = '0;
  txn_t        tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus_if.flush_i         = 1'b0;
    bus_if.in_valid_i      = 1'b0;
    bus_if.in_opr_a_i      = {$urandom, $urandom};
    bus_if.in_opr_b_i      = {$urandom, $urandom};
    bus_if.in_func_i       = FUNC_W'($urandom);
    bus_if.in_word_op_i    = 1'($urandom);
    bus_if.in_mul_i        = 1'($urandom);
    bus_if.in_div_i        = 1'($urandom);
    bus_if.in_rd_i         = RD_W'($urandom);
    bus_if.exu_res_i       = {$urandom, $urandom};
    bus_if.exu_valid_res_i = 1'b0;
    bus_if.exu_busy_i      = 1'b0;
    bus_if.wb_ready_i      = 1'b0;
  endtask

  task automatic drive_op(input int cls, input logic [63:0] a, input logic [63:0] b,
                          input logic [FUNC_W-1:0] func, input logic word,
                          input logic [RD_W-1:0] rd);
    bus_if.in_valid_i   = 1'b1;
    bus_if.in_opr_a_i   = a;
    bus_if.in_opr_b_i   = b;
    bus_if.in_func_i    = func;
    bus_if.in_word_op_i = word;
    bus_if.in_mul_i     = (cls == 1) || (cls == 3);
    bus_if.in_div_i     = (cls == 2) || (cls == 3);
    bus_if.in_rd_i      = rd;
  endtask

  task automatic chk_perf();
`ifdef EXU_PERF_CNT_EN
    chk("perf_issue", 64'(bus_if.perf_issue_o), m_issue);
    chk("perf_wait", 64'(bus_if.perf_wait_o), m_wait);
`else
    chk("perf_issue", 64'(bus_if.perf_issue_o), 64'd0);
    chk("perf_wait", 64'(bus_if.perf_wait_o), 64'd0);
`endif
  endtask

  function automatic txn_t mk(input int cls, input logic [63:0] a, input logic [63:0] b,
                              input logic [RD_W-1:0] rd, input int busy, lat, stall, fl,
                              input int es, ew, ewt, input logic ek);
    txn_t t;
    t.cls = cls; t.a = a; t.b = b; t.rd = rd;
    t.func = FUNC_W'(rd) ^ FUNC_W'(10); t.word = a[0];
    t.busy = busy; t.lat = lat; t.stall = stall; t.flush_at = fl;
    t.exp_start = es; t.exp_wbs = ew; t.exp_wait = ewt; t.exp_kill = ek;
    return t;
  endfunction

  // Transaction-level timing: ALU result shows 2 cycles after accept; a mul/div
  // starts once busy drops, result arrives lat cycles after start, visible 1 later.
  function automatic txn_t model(input txn_t t);
    txn_t m = t;
    int   ws, we;
    if (t.cls == 0) begin
      m.exp_start = 0; m.exp_wbs = 2; m.exp_wait = 0; m.exp_kill = 1'b0;
    end else begin
      m.exp_start = 1 + t.busy;
      m.exp_wbs   = m.exp_start + t.lat + 1;
      ws = m.exp_start + 1;
      we = m.exp_start + t.lat;
      if (t.flush_at != 0 && t.flush_at < we) we = t.flush_at;
      m.exp_wait  = (we >= ws) ? we - ws + 1 : 0;
      m.exp_kill  = (t.flush_at != 0) && (t.flush_at < m.exp_wbs);
    end
    return m;
  endfunction

  task automatic run_txn(input txn_t t);
    int          last, cap;
    logic [63:0] cap_data = '0;
    logic [63:0] r;
    bit          has_mul, has_div;
    has_mul = (t.cls == 1) || (t.cls == 3);
    has_div = (t.cls == 2);
    last = (t.flush_at != 0) ? t.flush_at : t.exp_wbs + t.stall;
    cap  = (t.cls == 0) ? 1 : 1 + t.busy + t.lat;
    for (int k = 0; k <= last; k++) begin
      bit   fl;
      logic wr;
      cyc();
      drive_idle();
      fl = (t.flush_at != 0) && (k == t.flush_at);
      bus_if.flush_i = fl;
      if (k == 0) drive_op(t.cls, t.a, t.b, t.func, t.word, t.rd);
      else if (k == t.exp_wbs + t.stall && !fl) bus_if.in_valid_i = 1'b0;
      else bus_if.in_valid_i = 1'($urandom);
      bus_if.exu_busy_i = (t.cls == 0) ? 1'($urandom) : (k >= 1 && k <= t.busy);
      r = {$urandom, $urandom};
      bus_if.exu_res_i = r;
      if (k == cap) cap_data = r;
      if (t.cls == 0) bus_if.exu_valid_res_i = 1'($urandom);
      else if (k == cap) bus_if.exu_valid_res_i = 1'b1;
      else if (k < 1 + t.busy || k >= t.exp_wbs) bus_if.exu_valid_res_i = 1'($urandom);
      else bus_if.exu_valid_res_i = 1'b0;
      if (fl) wr = 1'b1;
      else if (k < t.exp_wbs) wr = 1'($urandom);
      else wr = (k == t.exp_wbs + t.stall);
      bus_if.wb_ready_i = wr;
      #1;
      chk("exu_flush", 64'(bus_if.exu_flush_o), 64'(fl));
      chk("exu_kill", 64'(bus_if.exu_kill_o), fl ? 64'(t.exp_kill) : 64'd0);
      chk("in_ready", 64'(bus_if.in_ready_o),
          (k == 0) ? 64'd1 : fl ? 64'd0 : (k >= t.exp_wbs) ? 64'(wr) : 64'd0);
      chk("wb_valid", 64'(bus_if.wb_valid_o), 64'(!fl && k >= t.exp_wbs));
      chk("mul_start", 64'(bus_if.exu_mul_instr_o), 64'(!fl && k == t.exp_start && has_mul));
      chk("div_start", 64'(bus_if.exu_div_instr_o), 64'(!fl && k == t.exp_start && has_div));
      if (!fl && k >= t.exp_wbs) begin
        chk("wb_rd", 64'(bus_if.wb_rd_o), 64'(t.rd));
        chk("wb_data", bus_if.wb_data_o, cap_data);
      end
      if (k >= 1) begin
        chk("opr_a", bus_if.exu_opr_a_o, t.a);
        chk("opr_b", bus_if.exu_opr_b_o, t.b);
        chk("func", 64'(bus_if.exu_func_o), 64'(t.func));
        chk("word", 64'(bus_if.exu_word_op_o), 64'(t.word));
      end
    end
    // Idle cycle; after a flush, a stale result arrives and must be dropped.
    cyc();
    drive_idle();
    bus_if.exu_valid_res_i = (t.flush_at != 0);
    m_issue += 1;
    m_wait  += 64'(t.exp_wait);
    #1;
    chk("idle_in_ready", 64'(bus_if.in_ready_o), 64'd1);
    chk("idle_wb_valid", 64'(bus_if.wb_valid_o), 64'd0);
    chk("idle_kill", 64'(bus_if.exu_kill_o), 64'd0);
    chk_perf();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(bus_if.in_ready_o), 64'd1);
    chk({tag, "_wb_valid"}, 64'(bus_if.wb_valid_o), 64'd0);
    chk({tag, "_opr_a"}, bus_if.exu_opr_a_o, 64'd0);
    chk({tag, "_opr_b"}, bus_if.exu_opr_b_o, 64'd0);
    chk({tag, "_func"}, 64'(bus_if.exu_func_o), 64'd0);
    chk({tag, "_word"}, 64'(bus_if.exu_word_op_o), 64'd0);
    chk({tag, "_wb_rd"}, 64'(bus_if.wb_rd_o), 64'd0);
    chk({tag, "_wb_data"}, bus_if.wb_data_o, 64'd0);
    chk({tag, "_mul"}, 64'(bus_if.exu_mul_instr_o), 64'd0);
    chk({tag, "_div"}, 64'(bus_if.exu_div_instr_o), 64'd0);
    chk({tag, "_kill"}, 64'(bus_if.exu_kill_o), 64'd0);
    chk({tag, "_perf_issue"}, 64'(bus_if.perf_issue_o), 64'd0);
    chk({tag, "_perf_wait"}, 64'(bus_if.perf_wait_o), 64'd0);
  endtask

  initial begin
    txn_t t;
    //            cls a        b       rd bsy lat stl fl  st wbs wt kill
    tbl[0] = mk(0, 64'd5,    64'd7,  3, 0, 0, 0, 0, 0, 2, 0, 1'b0);
    tbl[1] = mk(1, 64'h1234, 64'h99, 4, 0, 4, 0, 0, 1, 6, 4, 1'b0);
    tbl[2] = mk(2, 64'hF00,  64'h3,  5, 3, 2, 0, 0, 4, 7, 2, 1'b0);
    tbl[3] = mk(1, 64'hAAA,  64'h5,  6, 0, 3, 0, 3, 1, 5, 2, 1'b1);
    tbl[4] = mk(0, 64'h77,   64'h88, 7, 0, 0, 5, 0, 0, 2, 0, 1'b0);
    tbl[5] = mk(3, 64'h42,   64'h43, 8, 0, 2, 0, 0, 1, 4, 2, 1'b0);
    tbl[6] = mk(2, 64'h9,    64'hA, 10, 2, 1, 0, 1, 3, 5, 0, 1'b1);
    tbl[7] = mk(0, 64'hB,    64'hC, 11, 0, 0, 0, 1, 0, 2, 0, 1'b0);
    tbl[8] = mk(0, 64'hD,    64'hE, 12, 0, 0, 2, 3, 0, 2, 0, 1'b0);
    tbl[9] = mk(2, 64'h1,    64'h2, 13, 1, 1, 1, 4, 2, 4, 1, 1'b0);

    reset = 1'b1;
    drive_idle();
    cyc();
    cyc();
    chk_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Writeback stalled 5 cycles, then a new op accepted on the handshake cycle.
    cyc(); drive_idle(); drive_op(0, 64'h11, 64'h22, 4'd3, 1'b1, 5'd9); #1;
    chk("b2b_accept1", 64'(bus_if.in_ready_o), 64'd1);
    cyc(); drive_idle(); bus_if.exu_res_i = 64'hABCD_0001; #1;
    chk("b2b_exec_wb_valid", 64'(bus_if.wb_valid_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(); drive_idle(); drive_op(0, 64'h33, 64'h44, 4'd5, 1'b0, 5'd12); #1;
      chk("stall_wb_valid", 64'(bus_if.wb_valid_o), 64'd1);
      chk("stall_wb_rd", 64'(bus_if.wb_rd_o), 64'd9);
      chk("stall_wb_data", bus_if.wb_data_o, 64'hABCD_0001);
      chk("stall_in_ready", 64'(bus_if.in_ready_o), 64'd0);
      chk("stall_opr_a", bus_if.exu_opr_a_o, 64'h11);
    end
    cyc(); drive_idle(); drive_op(0, 64'h33, 64'h44, 4'd5, 1'b0, 5'd12);
    bus_if.wb_ready_i = 1'b1; #1;
    chk("b2b_wb_valid", 64'(bus_if.wb_valid_o), 64'd1);
    chk("b2b_in_ready", 64'(bus_if.in_ready_o), 64'd1);
    cyc(); drive_idle(); bus_if.exu_res_i = 64'hBEEF_0002; #1;
    chk("b2b_exec2_wb_valid", 64'(bus_if.wb_valid_o), 64'd0);
    chk("b2b_exec2_opr_a", bus_if.exu_opr_a_o, 64'h33);
    chk("b2b_exec2_in_ready", 64'(bus_if.in_ready_o), 64'd0);
    cyc(); drive_idle(); bus_if.wb_ready_i = 1'b1; #1;
    chk("b2b_wb2_valid", 64'(bus_if.wb_valid_o), 64'd1);
    chk("b2b_wb2_rd", 64'(bus_if.wb_rd_o), 64'd12);
    chk("b2b_wb2_data", bus_if.wb_data_o, 64'hBEEF_0002);
    cyc(); drive_idle(); #1;
    m_issue += 2;
    chk("b2b_idle_wb_valid", 64'(bus_if.wb_valid_o), 64'd0);
    chk_perf();

    for (int i = 0; i < 250; i++) begin
      t = mk(int'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
             RD_W'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 5)),
             int'($urandom_range(0, 3)), 0, 0, 0, 0, 1'b0);
      t = model(t);
      if ($urandom_range(0, 4) == 0) t.flush_at = int'($urandom_range(1, t.exp_wbs + t.stall));
      t = model(t);
      run_txn(t);
    end

    // Async reset while a multiply sits in WAIT.
    cyc(); drive_idle(); drive_op(1, 64'h5555, 64'h77, 4'd2, 1'b1, 5'd21); #1;
    cyc(); drive_idle(); #1;
    chk("rst_seq_start", 64'(bus_if.exu_mul_instr_o), 64'd1);
    cyc(); drive_idle(); bus_if.exu_busy_i = 1'b1; #1;
    chk("rst_seq_wait_pulse", 64'(bus_if.exu_mul_instr_o), 64'd0);
    cyc(); drive_idle(); bus_if.exu_busy_i = 1'b1; #1;
    m_issue += 1;
    m_wait  += 1;
    chk_perf();
    #2;
    reset = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;
    m_issue = '0;
    m_wait  = '0;
    run_txn(tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
